sbox_fill_ctrl: RTL and testbench



---
 rtl/sbox_fill_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sbox_fill_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_fill_ctrl.sv
// sbox_fill_ctrl: sequences filling of a 256-entry S-box with a permutation
// of 0..255 built from candidate bytes supplied by a chaotic generator.
// Duplicates are detected with a 256-bit used-map and either dropped
// (default build) or resolved by linear probing when SBOX_LINEAR_PROBE_EN
// is defined.
module sbox_fill_ctrl #(
  parameter int unsigned MAX_CONSEC_REJ = 4096,
  parameter int unsigned REJ_CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cand_valid,
  input  logic [7:0]           cand_data,
  output logic                 cand_ready,
  output logic                 sbox_clr,
  output logic                 sbox_we,
  output logic [7:0]           sbox_wdata,
  output logic [8:0]           fill_count,
  output logic [REJ_CNT_W-1:0] reject_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FILL  = 3'd2,
`ifdef SBOX_LINEAR_PROBE_EN
    S_PROBE = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [REJ_CNT_W-1:0] REJ_MAX = {REJ_CNT_W{1'b1}};

  state_t       state;
  logic [255:0] used;
`ifdef SBOX_LINEAR_PROBE_EN
  logic [7:0]   probe;
`else
  localparam logic [16:0] CONSEC_LIMIT = 17'(MAX_CONSEC_REJ);
  logic [15:0]  consec;
`endif

  logic       accept;
  logic       hit;
  logic       wr_req;
  logic [7:0] wr_byte;
  logic       wr_last;

  // Decide whether a unique byte gets written this cycle and which byte it is.
  always_comb begin
    accept  = cand_valid & cand_ready;
    hit     = used[cand_data];
    wr_req  = 1'b0;
    wr_byte = cand_data;
    wr_last = (fill_count == 9'd255);
    if ((state == S_FILL) && accept && !hit) begin
      wr_req = 1'b1;
`ifdef SBOX_LINEAR_PROBE_EN
    end else if ((state == S_PROBE) && !used[probe]) begin
      wr_req  = 1'b1;
      wr_byte = probe;
`endif
    end else begin
      wr_req = 1'b0;
    end
  end

  // Control FSM with registered outputs; a write overrides the state update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      used         <= '0;
      cand_ready   <= 1'b0;
      sbox_clr     <= 1'b0;
      sbox_we      <= 1'b0;
      sbox_wdata   <= 8'd0;
      fill_count   <= 9'd0;
      reject_count <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef SBOX_LINEAR_PROBE_EN
      probe        <= 8'd0;
`else
      consec       <= 16'd0;
`endif
    end else begin
      sbox_clr <= 1'b0;
      sbox_we  <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_CLEAR;
            sbox_clr     <= 1'b1;
            used         <= '0;
            fill_count   <= 9'd0;
            reject_count <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
`ifndef SBOX_LINEAR_PROBE_EN
            consec       <= 16'd0;
`endif
          end
        end
        S_CLEAR: begin
          state      <= S_FILL;
          cand_ready <= 1'b1;
        end
        S_FILL: begin
          if (accept && hit) begin
            if (reject_count != REJ_MAX) begin
              reject_count <= reject_count + {{(REJ_CNT_W-1){1'b0}}, 1'b1};
            end
`ifdef SBOX_LINEAR_PROBE_EN
            state      <= S_PROBE;
            probe      <= cand_data + 8'd1;
            cand_ready <= 1'b0;
`else
            consec <= consec + 16'd1;
            if (({1'b0, consec} + 17'd1) == CONSEC_LIMIT) begin
              state      <= S_ERROR;
              error      <= 1'b1;
              busy       <= 1'b0;
              cand_ready <= 1'b0;
            end
`endif
          end
        end
`ifdef SBOX_LINEAR_PROBE_EN
        S_PROBE: begin
          if (used[probe]) begin
            probe <= probe + 8'd1;
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          cand_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase

      if (wr_req) begin
        sbox_we         <= 1'b1;
        sbox_wdata      <= wr_byte;
        used[wr_byte]   <= 1'b1;
        fill_count      <= fill_count + 9'd1;
`ifndef SBOX_LINEAR_PROBE_EN
        consec          <= 16'd0;
`endif
        if (wr_last) begin
          state      <= S_DONE;
          done       <= 1'b1;
          busy       <= 1'b0;
          cand_ready <= 1'b0;
        end else begin
          state      <= S_FILL;
          cand_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sbox_fill_ctrl.sv
// Directed self-checking bench for sbox_fill_ctrl (MAX_CONSEC_REJ = 4).
module tb_sbox_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cand_valid;
  logic [7:0]  cand_data;
  logic        cand_ready;
  logic        sbox_clr;
  logic        sbox_we;
  logic [7:0]  sbox_wdata;
  logic [8:0]  fill_count;
  logic [15:0] reject_count;
  logic        busy;
  logic        done;
  logic        error;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] wlog[$];
  int clr_cnt = 0;

  sbox_fill_ctrl #(.MAX_CONSEC_REJ(4), .REJ_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cand_valid(cand_valid), .cand_data(cand_data), .cand_ready(cand_ready),
    .sbox_clr(sbox_clr), .sbox_we(sbox_we), .sbox_wdata(sbox_wdata),
    .fill_count(fill_count), .reject_count(reject_count),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every S-box write and clear pulse shortly after each edge.
  always @(posedge clk) begin
    #1;
    if (sbox_we) wlog.push_back(sbox_wdata);
    if (sbox_clr) clr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one byte and hold it until the controller takes it.
  task automatic feed(input logic [7:0] b);
    int guard;
    guard = 0;
    cand_valid = 1'b1;
    cand_data  = b;
    while (!cand_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!cand_ready) check_eq("feed_ready", 32'(cand_ready), 32'd1);
    @(negedge clk);
    cand_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_log(input string tag, input logic [7:0] exp[$]);
    int bad;
    bad = 0;
    check_eq({tag, "_len"}, 32'(wlog.size()), 32'(exp.size()));
    foreach (exp[i]) if (i < wlog.size() && wlog[i] !== exp[i]) bad++;
    check_eq({tag, "_data"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int snap;
    logic [7:0] nb;
    rst = 1'b1; start = 1'b0; cand_valid = 1'b0; cand_data = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", 32'({cand_ready, sbox_clr, sbox_we, busy, done, error}), 32'd0);
    check_eq("rst_cnts", 32'(fill_count) + 32'(reject_count) + 32'(sbox_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full ascending fill.
    do_start();
    check_eq("t1_clr", 32'(sbox_clr), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("t1_ready", 32'(cand_ready), 32'd1);
    wlog.delete();
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      feed(8'(i));
      exp_q.push_back(8'(i));
    end
    check_eq("t1_we_last", 32'(sbox_we), 32'd1);
    check_eq("t1_wdata_last", 32'(sbox_wdata), 32'd255);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_fill", 32'(fill_count), 32'd256);
    check_eq("t1_ready_off", 32'(cand_ready), 32'd0);
    check_eq("t1_busy_off", 32'(busy), 32'd0);
    check_eq("t1_rej", 32'(reject_count), 32'd0);
    repeat (2) @(negedge clk);
    check_log("t1_log", exp_q);
    check_eq("t1_done_hold", 32'(done), 32'd1);

    // Restart from DONE, then 5,5,7.
    do_start();
    check_eq("t2_clr", 32'(sbox_clr), 32'd1);
    check_eq("t2_done_clr", 32'(done), 32'd0);
    check_eq("t2_fill_clr", 32'(fill_count), 32'd0);
    @(negedge clk);
    wlog.delete();
    feed(8'd5); feed(8'd5); feed(8'd7);
    repeat (2) @(negedge clk);
`ifdef SBOX_LINEAR_PROBE_EN
    exp_q = '{8'd5, 8'd6, 8'd7};
    check_eq("t2_fill", 32'(fill_count), 32'd3);
`else
    exp_q = '{8'd5, 8'd7};
    check_eq("t2_fill", 32'(fill_count), 32'd2);
`endif
    check_log("t2_log", exp_q);
    check_eq("t2_rej", 32'(reject_count), 32'd1);

    // start during FILL is ignored.
    snap = clr_cnt;
    do_start();
    @(negedge clk);
    check_eq("t5_clr_none", 32'(clr_cnt - snap), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd1);
    snap = 32'(fill_count);
    feed(8'd8);
    check_eq("t5_fill_cont", 32'(fill_count), 32'(snap + 1));

    // Fill to 100 unique, then reset mid-fill.
    nb = 8'd9;
    while (fill_count < 9'd100 && nb != 8'd0) begin
      feed(nb);
      nb = nb + 8'd1;
    end
    check_eq("t4_fill100", 32'(fill_count), 32'd100);
    cand_valid = 1'b1; cand_data = 8'd200;
    rst = 1'b1;
    snap = wlog.size();
    repeat (3) @(negedge clk);
    check_eq("t4_rst_outs", 32'({cand_ready, sbox_clr, sbox_we, busy, done, error}), 32'd0);
    check_eq("t4_rst_cnts", 32'(fill_count) + 32'(reject_count) + 32'(sbox_wdata), 32'd0);
    check_eq("t4_no_we", 32'(wlog.size() - snap), 32'd0);
    rst = 1'b0; cand_valid = 1'b0;
    @(negedge clk);
    check_eq("t4_idle_ready", 32'(cand_ready), 32'd0);
    do_start();
    @(negedge clk);
    wlog.delete();
    exp_q.delete();
    for (int i = 255; i >= 0; i--) begin
      feed(8'(i));
      exp_q.push_back(8'(i));
    end
    check_eq("t4_done", 32'(done), 32'd1);
    check_eq("t4_fill", 32'(fill_count), 32'd256);
    @(negedge clk);
    check_log("t4_log", exp_q);

`ifdef SBOX_LINEAR_PROBE_EN
    // Linear probing: duplicates resolve to the next free byte.
    do_start();
    @(negedge clk);
    wlog.delete();
    feed(8'd10); feed(8'd10);
    repeat (3) @(negedge clk);
    exp_q = '{8'd10, 8'd11};
    check_log("p1_log", exp_q);
    check_eq("p1_rej", 32'(reject_count), 32'd1);
    feed(8'd255); feed(8'd0); feed(8'd255);
    repeat (4) @(negedge clk);
    exp_q = '{8'd10, 8'd11, 8'd255, 8'd0, 8'd1};
    check_log("p2_log", exp_q);
    check_eq("p2_rej", 32'(reject_count), 32'd2);
    check_eq("p2_fill", 32'(fill_count), 32'd5);
    check_eq("p2_err", 32'(error), 32'd0);
`else
    // Consecutive duplicates force ERROR at the fourth.
    do_start();
    @(negedge clk);
    wlog.delete();
    feed(8'd0);
    feed(8'd0); feed(8'd0); feed(8'd0);
    check_eq("t3_err_pre", 32'(error), 32'd0);
    check_eq("t3_rej3", 32'(reject_count), 32'd3);
    feed(8'd0);
    check_eq("t3_err", 32'(error), 32'd1);
    check_eq("t3_ready_off", 32'(cand_ready), 32'd0);
    check_eq("t3_busy_off", 32'(busy), 32'd0);
    check_eq("t3_rej4", 32'(reject_count), 32'd4);
    cand_valid = 1'b1; cand_data = 8'd1;
    repeat (5) @(negedge clk);
    cand_valid = 1'b0;
    exp_q = '{8'd0};
    check_log("t3_log", exp_q);
    check_eq("t3_err_hold", 32'(error), 32'd1);
    check_eq("t3_fill", 32'(fill_count), 32'd1);
    do_start();
    check_eq("t3_clr", 32'(sbox_clr), 32'd1);
    check_eq("t3_err_clr", 32'(error), 32'd0);
    check_eq("t3_cnt_clr", 32'(fill_count) + 32'(reject_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
